fir_tap_mac: RTL and testbench

FIR_TAP_MAC -- requirements
Module: fir_tap_mac

---
 rtl/fir_tap_mac_if.sv | 25 ++
 rtl/fir_tap_mac.sv | 90 +++++++++
 tb/tb_fir_tap_mac.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_mac_if.sv
// Sample, coefficient and result handshake bundle for fir_tap_mac.
// The slave modport is the filter; the master modport is its driver.
interface fir_tap_mac_if #(
    parameter int DW = 12
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          coef_we;
    logic [3:0]    coef_addr;
    logic [DW-1:0] coef_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_tap_mac.sv
// Serial FIR filter: one multiply-accumulate per cycle over TAPS taps,
// Q1.11 coefficients, DW-bit wrap-around accumulator, valid/ready result.
module fir_tap_mac #(
    parameter int TAPS = 8,
    parameter int DW   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_tap_mac_if.slave  bus
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             state;
    logic [AW-1:0]          k;
    logic signed [DW-1:0]   acc;
    logic signed [DW-1:0]   x [TAPS];
    logic signed [DW-1:0]   h [TAPS];
    logic [DW-1:0]          out_q;

    logic signed [DW-1:0]   xk, hk, term, sum;
    logic signed [2*DW-1:0] prod;
    logic                   accept, coef_hit;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign coef_hit  = bus.coef_we && (state == IDLE) && (int'(bus.coef_addr) < TAPS);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_q;

    // Product keeps bits [DW+10:11] of the full product: truncating, no saturation.
    always_comb begin
        xk   = x[k];
        hk   = h[k];
        prod = (2*DW)'(xk) * (2*DW)'(hk);
        term = DW'(prod >>> 11);
        sum  = acc + term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            acc   <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        k     <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    k   <= k + AW'(1);
                    if (k == AW'(TAPS - 1)) begin
                        out_q <= sum;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                h[i] <= '0;
            end
        end else begin
            if (accept) begin
                x[0] <= $signed(bus.in_data);
                for (int unsigned i = 1; i < TAPS; i++) x[i] <= x[i-1];
            end
            // Coefficient write lands alongside an accept; tap 0 reads it next cycle.
            if (coef_hit) h[bus.coef_addr[AW-1:0]] <= $signed(bus.coef_data);
        end
    end
endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed bench for fir_tap_mac (TAPS=8, DW=12) with hand-computed results.
module tb_fir_tap_mac;
    localparam int TAPS = 8;
    localparam int DW   = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fir_tap_mac_if #(.DW(DW)) bus ();

    fir_tap_mac #(.TAPS(TAPS), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc;
    bit seen_valid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_coef(input logic [3:0] a, input logic [11:0] d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic accept(input string tag, input logic [11:0] s);
        chk({tag, "_ready"}, int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = s;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp, output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_data"}, int'(bus.out_data), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;

        // Asynchronous reset before the first clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", int'(bus.in_ready), 1);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 'h000);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Impulse: 2047*0.5 -> 0x3FF after 8 cycles, then 2047*0.25 -> 0x1FF
        set_coef(4'd0, 12'h400);
        set_coef(4'd1, 12'h200);
        accept("imp1", 12'h7FF);
        wait_out("imp1", 'h3FF, cyc);
        chk("imp1_latency", cyc, TAPS);
        tick();
        accept("imp2", 12'h000);
        wait_out("imp2", 'h1FF, cyc);
        tick();
        chk("held_valid", int'(bus.out_valid), 0);
        chk("held_data", int'(bus.out_data), 'h1FF);

        // Wrap-around: 2046, then 2046+2046 = 4092 -> -4
        set_coef(4'd0, 12'h7FF);
        set_coef(4'd1, 12'h7FF);
        accept("wrap1", 12'h7FF);
        wait_out("wrap1", 'h7FE, cyc);
        tick();
        accept("wrap2", 12'h7FF);
        wait_out("wrap2", 'hFFC, cyc);
        tick();

        // Most negative squared: -2048 * -2048 -> 0x800
        set_coef(4'd1, 12'h000);
        set_coef(4'd0, 12'h800);
        accept("minmin", 12'h800);
        wait_out("minmin", 'h800, cyc);
        tick();

        // Backpressure: 256 * -1.0 -> 0xF00 held for 10 cycles
        bus.out_ready = 1'b0;
        accept("bp", 12'h100);
        wait_out("bp", 'hF00, cyc);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 12'h7FF;
            tick();
            chk("bp_hold_valid", int'(bus.out_valid), 1);
            chk("bp_hold_data", int'(bus.out_data), 'hF00);
            chk("bp_hold_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_rel_ready", int'(bus.in_ready), 1);
        chk("bp_rel_valid", int'(bus.out_valid), 0);
        // x1 must be 256, not the pulsed 0x7FF: 256*0.5 -> 0x080
        set_coef(4'd0, 12'h000);
        set_coef(4'd1, 12'h400);
        accept("bp_nocons", 12'h000);
        wait_out("bp_nocons", 'h080, cyc);
        tick();

        // Coefficient write during MAC must be ignored
        accept("mid1", 12'h200);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd1;
        bus.coef_data = 12'h7FF;
        repeat (TAPS - 1) tick();
        bus.coef_we   = 1'b0;
        wait_out("mid1", 'h000, cyc);
        tick();
        // Out-of-range address also ignored; x=[256,512], h=[0,0.5] -> 0x100
        set_coef(4'd8, 12'h7FF);
        accept("mid2", 12'h100);
        wait_out("mid2", 'h100, cyc);
        tick();

        // Accept and coefficient write in one cycle: 1024*0.5 + 256*0.5 = 0x280
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 12'h400;
        accept("prec", 12'h400);
        bus.coef_we   = 1'b0;
        wait_out("prec", 'h280, cyc);
        tick();

        // Reset during MAC: outputs clear at once, no result appears
        accept("rstmac", 12'h7FF);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rstmac_ready", int'(bus.in_ready), 1);
        chk("rstmac_valid", int'(bus.out_valid), 0);
        chk("rstmac_data", int'(bus.out_data), 'h000);
        @(negedge clk) rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("rstmac_no_out", int'(seen_valid), 0);
        // Coefficients cleared by reset, so 0x7FF filters to zero
        accept("post_rst", 12'h7FF);
        wait_out("post_rst", 'h000, cyc);
        chk("post_rst_latency", cyc, TAPS);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
